// File: rtl/sha1_w_sched_if.sv
// Block-in / schedule-word-out bundle between the SHA-1 round controller
// side (master) and the message-schedule stage (slave).
interface sha1_w_sched_if;
    logic         valid;
    logic [511:0] block_in;
    logic [7:0]   t_in;
    logic [31:0]  w_out;
    logic         w_valid;
    logic [7:0]   w_idx;
    logic         busy;
    logic         sync_err;

    modport master (
        output valid, block_in, t_in,
        input  w_out, w_valid, w_idx, busy, sync_err
    );

    modport slave (
        input  valid, block_in, t_in,
        output w_out, w_valid, w_idx, busy, sync_err
    );
endinterface

// File: rtl/sha1_w_sched.sv
// SHA-1 message schedule: latches a 512-bit block and emits W0..W79 one per
// cycle from a 16-word sliding window, cross-checking the controller's t.
module sha1_w_sched #(
    parameter int ROUNDS = 80,
    parameter int WORD   = 32
) (
    input logic           clk,
    input logic           rst_n,
    sha1_w_sched_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_reg, state_next;
    logic [WORD-1:0] win_reg [16];
    logic [WORD-1:0] load_word [16];
    logic [WORD-1:0] mix_word;
    logic [WORD-1:0] win15_next;
    logic [7:0]      cnt_reg, cnt_next;
    logic            sync_err_reg, sync_err_next;
    logic            load_en;
    logic            shift_en;

    // W0 sits in the most significant word of the block.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_load
            assign load_word[gi] = bus.block_in[16*WORD-1-WORD*gi -: WORD];
        end
    endgenerate

    assign mix_word   = win_reg[13] ^ win_reg[8] ^ win_reg[2] ^ win_reg[0];
    assign win15_next = {mix_word[WORD-2:0], mix_word[WORD-1]};

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        sync_err_next = sync_err_reg;
        load_en       = 1'b0;
        shift_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.valid) begin
                    load_en       = 1'b1;
                    cnt_next      = 8'd0;
                    sync_err_next = 1'b0;
                    state_next    = RUN;
                end
            end
            RUN: begin
                shift_en = 1'b1;
                if (bus.t_in != cnt_reg) begin
                    sync_err_next = 1'b1;
                end
                if (cnt_reg == 8'(ROUNDS - 1)) begin
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            sync_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sync_err_reg <= sync_err_next;
        end
    end

    // Window shifts toward index 0; the new word enters at index 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                win_reg[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < 16; i++) begin
                win_reg[i] <= load_word[i];
            end
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                win_reg[i] <= win_reg[i+1];
            end
            win_reg[15] <= win15_next;
        end
    end

    assign bus.w_out    = win_reg[0];
    assign bus.w_valid  = (state_reg == RUN);
    assign bus.busy     = (state_reg == RUN);
    assign bus.w_idx    = cnt_reg;
    assign bus.sync_err = sync_err_reg;

endmodule
